// File: rtl/tp_mux_if.sv
// Bus bundle for the test-point mux controller: probe inputs, slot config
// port and the registered test-point outputs.
interface tp_mux_if #(
  parameter int NPROBE = 64,
  parameter int NTP    = 16,
  parameter int SELW   = 6,
  parameter int AW     = 4
);
  logic [NPROBE-1:0] probe;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [SELW+2:0]   cfg_wdata;
  logic              clr_sticky;
  logic [SELW+2:0]   cfg_rdata;
  logic [NTP-1:0]    tp_out;
  logic [NTP-1:0]    tp_dir;

  // Side that drives probes and config (bench / host logic).
  modport master (
    output probe, cfg_we, cfg_addr, cfg_wdata, clr_sticky,
    input  cfg_rdata, tp_out, tp_dir
  );

  // Side implemented by tp_mux_ctrl.
  modport slave (
    input  probe, cfg_we, cfg_addr, cfg_wdata, clr_sticky,
    output cfg_rdata, tp_out, tp_dir
  );
endinterface

// File: rtl/tp_mux_ctrl.sv
// Test-point mux controller: each slot picks one registered probe and drives
// it out as a direct copy, a stretched pulse, a toggle or a sticky flag.
// Config word is {dir, mode[1:0], sel[SELW-1:0]}.
module tp_mux_ctrl #(
  parameter int             NPROBE  = 64,
  parameter int             NTP     = 16,
  parameter int             SELW    = 6,
  parameter int             AW      = 4,
  parameter int             STRETCH = 8,
  parameter logic [NTP-1:0] DIR_RST = '1
) (
  input logic   clk,
  input logic   rst,
  tp_mux_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_STRETCH = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_STICKY  = 2'b11
  } mode_e;

  localparam logic [SELW:0] SEL_LIMIT    = (SELW+1)'(NPROBE);
  localparam logic [AW:0]   ADDR_LIMIT   = (AW+1)'(NTP);
  localparam logic [7:0]    STRETCH_LOAD = 8'(STRETCH - 1);

  logic [NPROBE-1:0] stage1_q;
  logic [SELW-1:0]   sel_q  [NTP];
  mode_e             mode_q [NTP];
  logic [NTP-1:0]    dir_q;
  logic [NTP-1:0]    prev_q, prev_d;
  logic [NTP-1:0]    out_q, out_d;
  logic [7:0]        cnt_q  [NTP];
  logic [7:0]        cnt_d  [NTP];
  logic [SELW+2:0]   rdata_q;

  logic              addr_ok;
  logic              wr_en;
  logic [NTP-1:0]    wr_hit;
  logic [NTP-1:0]    samp;
  logic [NTP-1:0]    rise;

  assign addr_ok = ({1'b0, bus.cfg_addr} < ADDR_LIMIT);
  assign wr_en   = bus.cfg_we && addr_ok;

  // Decode which slot (if any) is being written this cycle.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NTP; i++) begin
      wr_hit[i] = wr_en && (bus.cfg_addr == AW'(i));
    end
  end

  // Per-slot probe selection; an out-of-range select reads as 0.
  always_comb begin
    samp = '0;
    for (int i = 0; i < NTP; i++) begin
      if ({1'b0, sel_q[i]} < SEL_LIMIT) samp[i] = stage1_q[sel_q[i]];
    end
  end

  assign rise = samp & ~prev_q;

  // Per-slot output behaviour by mode, with a write resetting the slot.
  // NOTE: combinational next-state uses blocking '='; the registers below
  // take these values with '<=' only, so evaluation order never matters.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    out_d  = out_q;
    prev_d = samp;
    for (int i = 0; i < NTP; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case (mode_q[i])
        MODE_DIRECT:  out_d[i] = samp[i];
        MODE_STRETCH: begin
          if (samp[i]) begin
            cnt_d[i] = STRETCH_LOAD;
            out_d[i] = 1'b1;
          end else if (cnt_q[i] != 8'd0) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
            out_d[i] = 1'b1;
          end else begin
            out_d[i] = 1'b0;
          end
        end
        MODE_TOGGLE:  if (rise[i]) out_d[i] = ~out_q[i];
        MODE_STICKY: begin
          // Clear beats a coincident set.
          if (bus.clr_sticky)  out_d[i] = 1'b0;
          else if (samp[i])    out_d[i] = 1'b1;
        end
      endcase
      // prev=1 masks a spurious rise on the first sample after a rewrite.
      if (wr_hit[i]) begin
        cnt_d[i]  = 8'd0;
        out_d[i]  = 1'b0;
        prev_d[i] = 1'b1;
      end
    end
  end

  // Probe capture stage and per-slot datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      out_q    <= '0;
      prev_q   <= '1;
      for (int i = 0; i < NTP; i++) cnt_q[i] <= 8'd0;
    end else begin
      stage1_q <= bus.probe;
      out_q    <= out_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot configuration table; new values take effect the cycle after a write.
  // NOTE: the table is built from flops and is fully reset, since every slot
  // has a defined power-on select, mode and direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTP; i++) begin
        sel_q[i]  <= (i < NPROBE) ? SELW'(i) : '0;
        mode_q[i] <= MODE_DIRECT;
      end
      dir_q <= DIR_RST;
    end else if (wr_en) begin
      sel_q[bus.cfg_addr]  <= bus.cfg_wdata[SELW-1:0];
      mode_q[bus.cfg_addr] <= mode_e'(bus.cfg_wdata[SELW +: 2]);
      dir_q[bus.cfg_addr]  <= bus.cfg_wdata[SELW+2];
    end
  end

  // Registered readback; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= '0;
    else if (addr_ok) rdata_q <= {dir_q[bus.cfg_addr], mode_q[bus.cfg_addr], sel_q[bus.cfg_addr]};
    else              rdata_q <= '0;
  end

  assign bus.tp_out    = out_q;
  assign bus.tp_dir    = dir_q;
  assign bus.cfg_rdata = rdata_q;

endmodule

// File: tb/tb_tp_mux_ctrl.sv
// Self-checking bench for tp_mux_ctrl: directed vectors, a per-cycle
// comparison against a behavioural model, and literal spot checks.
module tb_tp_mux_ctrl;

  localparam int             NPROBE  = 48;
  localparam int             NTP     = 12;
  localparam int             SELW    = 6;
  localparam int             AW      = 4;
  localparam int             STRETCH = 8;
  localparam int             CW      = SELW + 3;
  localparam logic [NTP-1:0] DIR_RST = 12'hA5F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tp_mux_if #(.NPROBE(NPROBE), .NTP(NTP), .SELW(SELW), .AW(AW)) bus ();

  tp_mux_ctrl #(
    .NPROBE(NPROBE), .NTP(NTP), .SELW(SELW), .AW(AW),
    .STRETCH(STRETCH), .DIR_RST(DIR_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks;
  int n_fail;

  // Behavioural model: outputs follow from what each slot has seen, not
  // from counters: stretch = "a hit within the last STRETCH cycles",
  // toggle = "parity of rises", sticky = "seen since last clear".
  int                m_sel      [NTP];
  int                m_mode     [NTP];
  bit                m_last_s   [NTP];
  int                m_last_hit [NTP];
  logic [NTP-1:0]    m_dir;
  logic [NTP-1:0]    m_out;
  logic [NPROBE-1:0] m_stage1;
  logic [CW-1:0]     m_rdata;
  int                m_cyc;
  bit                model_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_update();
    int   a;
    logic s;
    a = int'(bus.cfg_addr);
    if (rst) begin
      m_stage1 = '0;
      m_rdata  = '0;
      m_out    = '0;
      m_dir    = DIR_RST;
      for (int i = 0; i < NTP; i++) begin
        m_sel[i]      = (i < NPROBE) ? i : 0;
        m_mode[i]     = 0;
        m_last_s[i]   = 1'b1;
        m_last_hit[i] = -1000;
      end
      model_valid = 1'b1;
    end else begin
      if (a < NTP) m_rdata = {m_dir[a], 2'(m_mode[a]), SELW'(m_sel[a])};
      else         m_rdata = '0;
      for (int i = 0; i < NTP; i++) begin
        s = (m_sel[i] < NPROBE) ? m_stage1[m_sel[i]] : 1'b0;
        if (bus.cfg_we && a == i) begin
          m_out[i]      = 1'b0;
          m_last_s[i]   = 1'b1;
          m_last_hit[i] = -1000;
        end else begin
          case (m_mode[i])
            0: m_out[i] = s;
            1: begin
              if (s) m_last_hit[i] = m_cyc;
              m_out[i] = ((m_cyc - m_last_hit[i]) < STRETCH);
            end
            2: if (s && !m_last_s[i]) m_out[i] = ~m_out[i];
            default: begin
              if (bus.clr_sticky) m_out[i] = 1'b0;
              else if (s)         m_out[i] = 1'b1;
            end
          endcase
          m_last_s[i] = s;
        end
      end
      if (bus.cfg_we && a < NTP) begin
        m_dir[a]  = bus.cfg_wdata[CW-1];
        m_mode[a] = int'(bus.cfg_wdata[SELW +: 2]);
        m_sel[a]  = int'(bus.cfg_wdata[SELW-1:0]);
      end
      m_stage1 = bus.probe;
    end
    m_cyc++;
  endtask

  task automatic compare();
    if (model_valid) begin
      check("tp_out",    64'(bus.tp_out),    64'(m_out));
      check("tp_dir",    64'(bus.tp_dir),    64'(m_dir));
      check("cfg_rdata", 64'(bus.cfg_rdata), 64'(m_rdata));
    end
  endtask

  // One clock: inputs held across the rising edge, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input int addr, input logic d, input logic [1:0] m, input int sel);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = AW'(addr);
    bus.cfg_wdata = {d, m, SELW'(sel)};
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse(input int idx);
    bus.probe[idx] = 1'b1;
    step();
    bus.probe[idx] = 1'b0;
    step();
  endtask

  // Pulse PROBE[5] at k=0 (and k=3 if asked), count high cycles and rising edges of slot 0.
  task automatic stretch_run(input bit second, output int hi, output int rises);
    logic last;
    hi = 0; rises = 0; last = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.probe[5] = (k == 0) || (second && k == 3);
      step();
      if (bus.tp_out[0]) hi++;
      if (bus.tp_out[0] && !last) rises++;
      last = bus.tp_out[0];
    end
    bus.probe[5] = 1'b0;
  endtask

  initial begin
    int hi, rises;
    n_checks = 0; n_fail = 0; model_valid = 1'b0; m_cyc = 0;
    rst = 1'b1;
    bus.probe = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
    bus.cfg_wdata = '0; bus.clr_sticky = 1'b0;
    step(); step();
    check("rst_tp_out", 64'(bus.tp_out),    64'h0);
    check("rst_tp_dir", 64'(bus.tp_dir),    64'hA5F);
    check("rst_rdata",  64'(bus.cfg_rdata), 64'h0);
    rst = 1'b0;

    // Reset config maps slot i to probe i in direct mode: two-cycle latency.
    bus.probe = 48'h555; step(); step();
    check("direct_pat1", 64'(bus.tp_out), 64'h555);
    bus.probe = 48'hAAA; step();
    check("direct_pat2_n1", 64'(bus.tp_out), 64'h555);
    step();
    check("direct_pat2_n2", 64'(bus.tp_out), 64'hAAA);
    bus.probe = 48'hF0F0_0000_0C3C; step(); step();
    bus.probe = '0; step(); step();

    // Direct latency on a rewritten slot.
    wr(3, 1'b0, 2'b00, 10); step();
    bus.probe[10] = 1'b1; step();
    check("direct_n1", 64'(bus.tp_out[3]), 64'h0);
    bus.probe[10] = 1'b0; step();
    check("direct_n2", 64'(bus.tp_out[3]), 64'h1);
    check("direct_dir", 64'(bus.tp_dir[3]), 64'h0);
    step();
    check("direct_n3", 64'(bus.tp_out[3]), 64'h0);

    // Stretch: single pulse and a retrigger three cycles later.
    wr(0, 1'b0, 2'b01, 5); step();
    stretch_run(1'b0, hi, rises);
    check("stretch_single_hi",    64'(hi),    64'd8);
    check("stretch_single_rises", 64'(rises), 64'd1);
    stretch_run(1'b1, hi, rises);
    check("stretch_double_hi",    64'(hi),    64'd11);
    check("stretch_double_rises", 64'(rises), 64'd1);

    // Toggle: 0 -> 1 -> 0 -> 1, held level adds nothing.
    wr(1, 1'b1, 2'b10, 20); step();
    check("toggle_init", 64'(bus.tp_out[1]), 64'h0);
    pulse(20);
    check("toggle_1", 64'(bus.tp_out[1]), 64'h1);
    step(); step();
    pulse(20);
    check("toggle_2", 64'(bus.tp_out[1]), 64'h0);
    step();
    bus.probe[20] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("toggle_3_held", 64'(bus.tp_out[1]), 64'h1);
    bus.probe[20] = 1'b0; step(); step();
    check("toggle_fall", 64'(bus.tp_out[1]), 64'h1);

    // Sticky: set, hold, clear-wins, and reassert only if probe persists.
    wr(2, 1'b1, 2'b11, 30); step();
    pulse(30);
    check("sticky_set", 64'(bus.tp_out[2]), 64'h1);
    step(); step(); step();
    check("sticky_hold", 64'(bus.tp_out[2]), 64'h1);
    bus.probe[30] = 1'b1; bus.probe[5] = 1'b1; step();
    bus.probe[5] = 1'b0; bus.clr_sticky = 1'b1; step();
    check("sticky_clr_wins", 64'(bus.tp_out[2]), 64'h0);
    check("clr_no_toggle",   64'(bus.tp_out[1]), 64'h1);
    check("clr_no_stretch",  64'(bus.tp_out[0]), 64'h1);
    bus.clr_sticky = 1'b0; step();
    check("sticky_reassert", 64'(bus.tp_out[2]), 64'h1);
    bus.probe[30] = 1'b0; step(); step();
    bus.probe[30] = 1'b1; step();
    bus.probe[30] = 1'b0; bus.clr_sticky = 1'b1; step();
    check("sticky_clr2", 64'(bus.tp_out[2]), 64'h0);
    bus.clr_sticky = 1'b0; step();
    check("sticky_stay_clear", 64'(bus.tp_out[2]), 64'h0);

    // Out-of-range write is ignored and reads back zero.
    wr(NTP, 1'b0, 2'b11, 7);
    check("oor_rdata_w", 64'(bus.cfg_rdata), 64'h0);
    step();
    check("oor_rdata", 64'(bus.cfg_rdata), 64'h0);
    check("oor_tp_dir", 64'(bus.tp_dir), 64'hA56);

    // Read-during-write of slot 4 returns old, then new.
    bus.cfg_addr = AW'(4); step();
    check("rd4_old", 64'(bus.cfg_rdata), 64'h104);
    wr(4, 1'b0, 2'b00, NPROBE);
    check("rd4_during", 64'(bus.cfg_rdata), 64'h104);
    step();
    check("rd4_new", 64'(bus.cfg_rdata), 64'h030);
    bus.probe = '1;
    for (int k = 0; k < 4; k++) step();
    check("sel_oor_zero", 64'(bus.tp_out[4]), 64'h0);
    bus.probe = '0; step(); step();

    // Reset during an active stretch and a set sticky, with a write pending.
    bus.probe[5] = 1'b1; step();
    bus.probe[5] = 1'b0; step(); step();
    check("pre_rst_stretch", 64'(bus.tp_out[0]), 64'h1);
    check("pre_rst_sticky",  64'(bus.tp_out[2]), 64'h1);
    rst = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = AW'(5);
    bus.cfg_wdata = '1; bus.clr_sticky = 1'b0; bus.probe[7] = 1'b1;
    step();
    check("mid_rst_tp_out", 64'(bus.tp_out),    64'h0);
    check("mid_rst_tp_dir", 64'(bus.tp_dir),    64'hA5F);
    check("mid_rst_rdata",  64'(bus.cfg_rdata), 64'h0);
    rst = 1'b0; bus.cfg_we = 1'b0;
    for (int i = 0; i < NTP; i++) begin
      logic [CW-1:0] expv;
      bus.cfg_addr = AW'(i);
      step();
      expv = {DIR_RST[i], 2'b00, SELW'(i)};
      check($sformatf("rst_cfg_%0d", i), 64'(bus.cfg_rdata), 64'(expv));
    end
    bus.probe = '0; step(); step();
    check("post_rst_direct7", 64'(bus.tp_out[7]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tp_mux_ctrl.md
TP_MUX_CTRL -- requirements
Module: tp_mux_ctrl

Interface
REQ-001 Parameter NPROBE, default 64: number of probe inputs.
REQ-002 Parameter NTP, default 16: number of test-point slots.
REQ-003 Parameter SELW, default 6: probe-select field width; the block SHALL support 2^SELW >= NPROBE.
REQ-004 Parameter AW, default 4: config address width; the block SHALL support 2^AW >= NTP.
REQ-005 Parameter STRETCH, default 8, range 2..255: minimum high time of a stretched pulse, in cycles.
REQ-006 Parameter DIR_RST, default all ones: reset direction per slot (1 = tri-state/input, 0 = drive).
REQ-007 The block SHALL use one clock and a synchronous, active-high reset, with the following ports:
- CLK, input, 1: sole clock; all state changes on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- PROBE, input, NPROBE: asynchronous-origin debug signals.
- CFG_WE, input, 1: write strobe for the slot config.
- CFG_ADDR, input, AW: slot index for write and readback.
- CFG_WDATA, input, SELW+3: config word {dir, mode[1:0], sel[SELW-1:0]}.
- CLR_STICKY, input, 1: clears all sticky-mode outputs.
- CFG_RDATA, output, SELW+3: registered readback of the config at CFG_ADDR.
- TP_OUT, output, NTP: registered test-point drive values.
- TP_DIR, output, NTP: per-slot IOBUF T control (1 = tri-state, 0 = drive).

Function
REQ-010 The block SHALL register PROBE once (stage 1) before any selection.
REQ-011 Each slot SHALL select sample s = stage1[sel]; if sel >= NPROBE, s SHALL be 0.
REQ-012 Each slot SHALL keep a prev register for edge detection; rise = s & ~prev.
REQ-013 mode 00 (direct): TP_OUT[i] <= s. A PROBE change in cycle n SHALL appear on TP_OUT in cycle n+2.
REQ-014 mode 01 (stretch): on s=1, the block SHALL load cnt=STRETCH-1 and drive output 1.
- While cnt>0 with s=0, it SHALL decrement cnt and drive output 1.
- At cnt=0 with s=0, it SHALL drive output 0.
- A 1-cycle probe pulse SHALL therefore produce exactly STRETCH high cycles.
- The counter SHALL be 8 bits wide.
REQ-015 mode 10 (toggle): TP_OUT[i] SHALL invert on each rise and otherwise hold.
REQ-016 mode 11 (sticky): TP_OUT[i] SHALL set on s=1 and clear on CLR_STICKY. When both occur in the same cycle, clear SHALL win.
REQ-017 A write SHALL occur when CFG_WE=1 and CFG_ADDR < NTP; writes to CFG_ADDR >= NTP SHALL be ignored.
REQ-018 In the write cycle, for the addressed slot only, the block SHALL:
- load cnt=0, TP_OUT[i]=0, and prev=1, so no rise is detected in the first sample after a write;
- apply the new sel/mode from the next cycle;
- take the new dir on TP_DIR in the next cycle.
REQ-019 Other slots SHALL be unaffected by a write to a different slot.
REQ-020 CFG_RDATA SHALL equal the config at CFG_ADDR one cycle after CFG_ADDR is presented.
- CFG_RDATA SHALL be 0 when CFG_ADDR >= NTP.
- When the read address is written in the same cycle, CFG_RDATA SHALL return the old value.
REQ-021 TP_DIR[i] SHALL come directly from the dir config register.
REQ-022 CLR_STICKY SHALL have no effect on slots in modes 00, 01, and 10.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 While RST=1, the block SHALL load:
- stage1 = 0, cnt = 0, prev = 1, TP_OUT = 0, CFG_RDATA = 0;
- for each slot i: sel = (i < NPROBE ? i : 0), mode = 00, dir = DIR_RST[i].
REQ-031 RST SHALL take priority over CFG_WE and CLR_STICKY.
REQ-032 Reset mid-stretch SHALL terminate the pulse in the next cycle.
REQ-033 The block SHALL resume normal operation in the first cycle after RST falls.

Verification
REQ-040 Direct latency: reset, write slot 3 = {0,00,sel=10}, pulse PROBE[10] high at cycle n -> TP_OUT[3] high at n+2 only, and TP_DIR[3]=0.
REQ-041 Stretch: slot 0 = {0,01,sel=5}, STRETCH=8, 1-cycle pulse on PROBE[5] -> TP_OUT[0] high exactly 8 cycles. Second pulse 3 cycles after the first -> high continuous until 8 cycles after the second pulse.
REQ-042 Toggle: slot 1 mode 10, three rising edges on the selected probe -> TP_OUT[1] goes 0->1->0->1. A level held high produces no further toggles.
REQ-043 Sticky: slot 2 mode 11, probe pulse -> TP_OUT[2] stays 1. CLR_STICKY coincident with a new probe pulse -> TP_OUT[2]=0 in that cycle, and 1 the next cycle only if the probe is still high.
REQ-044 Config/readback:
- write CFG_ADDR=NTP (out of range) -> no slot changes, and CFG_RDATA=0;
- write slot 4 while reading slot 4 -> old value, then new value the next cycle;
- sel=NPROBE -> TP_OUT[4] stays 0.
REQ-045 Reset mid-operation: assert RST during an active stretch and a set sticky -> next cycle TP_OUT=0, TP_DIR=DIR_RST, and CFG_RDATA for slot i reads {DIR_RST[i],00,i}.
